cmd_cfg_dump_engine: RTL

//  Host-command decoder, config register file and capture-RAM dump engine for the logic analyzer.

---
 rtl/cmd_cfg_dump_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cmd_cfg_dump_engine.sv
// cmd_cfg_dump_engine
// Host-command decoder, byte-wide config register file and capture-RAM dump engine for the
// logic analyzer. Decodes 16-bit host commands (READ / WRITE / DUMP / reserved), answers each
// with a response byte and streams a full channel of the circular capture RAM, oldest to newest.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   cmd               [15:14] opcode, [13:8] reg address ([10:8] dump channel), [7:0] data
//   cmd_rdy           command valid, held by the receiver until clr_cmd_rdy
//   resp_sent         one-cycle pulse from transmitter: current response byte is out
//   set_capture_done  sets reg0 bit 5
//   ram_addr          newest sample address written by capture_cntrl
//   rdata             RAM read data, channel n at [n*8-1 -: 8], one cycle after raddr
//   raddr             RAM read address
//   cfg_regs          register file, reg n at [n*8+7 -: 8]
//   resp              response byte, held between send_resp pulses
//   send_resp         one-cycle pulse: transmit resp
//   clr_cmd_rdy       one-cycle pulse: command fully processed
module cmd_cfg_dump_engine #(
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned ENTRIES  = 384,
  parameter int unsigned LOG2     = 9,
  parameter int unsigned NUM_REGS = 17,
  parameter logic [NUM_REGS*8-1:0] RST_VALS = {8'h01, 8'h00, 8'hC8, 8'h06, 8'h00, 8'h00, 8'h00,
                                               8'h00, 8'h55, 8'hAA, 8'h00, {5{8'h01}}, 8'h03}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           cmd,
  input  logic                  cmd_rdy,
  input  logic                  resp_sent,
  input  logic                  set_capture_done,
  input  logic [LOG2-1:0]       ram_addr,
  input  logic [NUM_CH*8-1:0]   rdata,
  output logic [LOG2-1:0]       raddr,
  output logic [NUM_REGS*8-1:0] cfg_regs,
  output logic [7:0]            resp,
  output logic                  send_resp,
  output logic                  clr_cmd_rdy
);

  localparam logic [LOG2-1:0] LastAddr = LOG2'(ENTRIES - 1);
  localparam logic [7:0]      RespAck  = 8'hA5;
  localparam logic [7:0]      RespNak  = 8'hEE;

  typedef enum logic [2:0] {StIdle, StRespWait, StDmpRd, StDmpSend, StDmpWait} state_e;

  state_e                  state_q, state_d;
  logic [NUM_REGS*8-1:0]   regs_q, regs_d;
  logic [7:0]              resp_q, resp_d;
  logic                    send_q, send_d;
  logic                    clr_q, clr_d;
  logic [LOG2-1:0]         raddr_q, raddr_d;
  logic [LOG2-1:0]         cnt_q, cnt_d;
  logic [2:0]              ch_q, ch_d;

  logic [1:0] op;
  logic [5:0] addr;
  logic [2:0] ch;
  logic [7:0] data;
  logic       addr_ok, ch_ok;
  logic [7:0] rd_byte, dump_byte;

  assign op      = cmd[15:14];
  assign addr    = cmd[13:8];
  assign ch      = cmd[10:8];
  assign data    = cmd[7:0];
  assign addr_ok = int'(addr) < NUM_REGS;
  assign ch_ok   = (ch != 3'd0) && (int'(ch) <= NUM_CH);

  always_comb begin
    rd_byte = RespNak;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(addr) == i) rd_byte = regs_q[i*8 +: 8];
    end
  end

  always_comb begin
    dump_byte = 8'h00;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (int'(ch_q) == i) dump_byte = rdata[i*8-1 -: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    resp_d  = resp_q;
    send_d  = 1'b0;
    clr_d   = 1'b0;
    raddr_d = raddr_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;

    unique case (state_q)
      StIdle: begin
        // cmd_rdy is still high for the cycle in which clr_cmd_rdy is out; skip it.
        if (cmd_rdy && !clr_q) begin
          state_d = StRespWait;
          send_d  = 1'b1;
          unique case (op)
            2'b00: resp_d = rd_byte;
            2'b01: begin
              resp_d = addr_ok ? RespAck : RespNak;
              for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_ok && int'(addr) == i) regs_d[i*8 +: 8] = data;
              end
            end
            2'b10: begin
              if (ch_ok) begin
                // Oldest sample sits just after the newest one in the circular buffer.
                raddr_d = (ram_addr == LastAddr) ? '0 : ram_addr + LOG2'(1);
                cnt_d   = '0;
                ch_d    = ch;
                send_d  = 1'b0;
                state_d = StDmpRd;
              end else begin
                resp_d = RespNak;
              end
            end
            default: resp_d = RespNak;
          endcase
        end
      end
      StRespWait: begin
        if (resp_sent) begin
          clr_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StDmpRd: state_d = StDmpSend;
      StDmpSend: begin
        resp_d  = dump_byte;
        send_d  = 1'b1;
        state_d = StDmpWait;
      end
      StDmpWait: begin
        if (resp_sent) begin
          if (cnt_q == LastAddr) begin
            clr_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + LOG2'(1);
            raddr_d = (raddr_q == LastAddr) ? '0 : raddr_q + LOG2'(1);
            state_d = StDmpRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture-done event wins over a coincident write to reg0 bit 5.
    if (set_capture_done) regs_d[5] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      regs_q  <= RST_VALS;
      resp_q  <= 8'h00;
      send_q  <= 1'b0;
      clr_q   <= 1'b0;
      raddr_q <= '0;
      cnt_q   <= '0;
      ch_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      resp_q  <= resp_d;
      send_q  <= send_d;
      clr_q   <= clr_d;
      raddr_q <= raddr_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
    end
  end

  assign raddr       = raddr_q;
  assign cfg_regs    = regs_q;
  assign resp        = resp_q;
  assign send_resp   = send_q;
  assign clr_cmd_rdy = clr_q;

endmodule
